// File: rtl/pc_sequencer_if.sv
// Bus between the fetch-stage control and the PC sequencer.
//   en         : advance enable (0 = stall)
//   op         : 0 INC, 1 JMP, 2 BRA, 3 CALL, 4 RET, 5-7 HOLD
//   target     : absolute address (JMP/CALL) or signed offset (BRA)
//   pc         : current program counter
//   depth_o    : valid return-stack entries
//   fault      : sticky fault flag
//   fault_code : 0 none, 1 call overflow, 2 return underflow
// master drives the command side; slave is the sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) ();
  localparam int SPW = $clog2(DEPTH + 1);

  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   depth_o;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (output en, op, target, input pc, depth_o, fault, fault_code);
  modport slave  (input en, op, target, output pc, depth_o, fault, fault_code);
endinterface

// File: rtl/pc_sequencer.sv
// Configurable-width program-counter sequencer for the Calcu-16 fetch stage.
// Supports increment, absolute jump, signed relative branch, stall and
// call/return through an internal return-address stack. Stack overflow and
// underflow raise a sticky fault that freezes all state until reset.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pc_sequencer_if.slave (en/op/target in; pc/depth_o/fault/fault_code out)
module pc_sequencer #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRA  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HOLD = 3'd5
  } op_t;

  typedef enum logic {
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_q, pc_next;
  logic [SPW-1:0]   depth_q, depth_next;
  logic [1:0]       code_q, code_next;
  logic             push;
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] stack [DEPTH];

  assign pc_inc = pc_q + WIDTH'(1);
  // Indices are only used when the access is in range, so truncation is safe.
  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - SPW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RUN;
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      code_q  <= '0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      depth_q <= depth_next;
      code_q  <= code_next;
    end
  end

  // Stack RAM carries no reset; entries at or above depth_q are never read.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    depth_next = depth_q;
    code_next  = code_q;
    push       = 1'b0;
    if (state == S_RUN && bus.en) begin
      case (op_t'(bus.op))
        OP_INC: pc_next = pc_inc;
        OP_JMP: pc_next = bus.target;
        // Modular add of the two's-complement offset to the current pc.
        OP_BRA: pc_next = pc_q + bus.target;
        OP_CALL: begin
          if (depth_q == SPW'(DEPTH)) begin
            state_next = S_FAULT;
            code_next  = 2'd1;
          end else begin
            push       = 1'b1;
            depth_next = depth_q + SPW'(1);
            pc_next    = bus.target;
          end
        end
        OP_RET: begin
          if (depth_q == '0) begin
            state_next = S_FAULT;
            code_next  = 2'd2;
          end else begin
            depth_next = depth_q - SPW'(1);
            pc_next    = stack[rd_idx];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.pc         = pc_q;
    bus.depth_o    = depth_q;
    bus.fault      = (state == S_FAULT);
    bus.fault_code = code_q;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (WIDTH=16, DEPTH=8, RESET_VECTOR=0):
// a directed vector table, hand-written fault/reset sequences, and a
// randomized run against a queue-based reference model.
module tb_pc_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic and a queue as the return stack.
  int pc_m;
  int stk_m[$];
  int flt_m;
  int code_m;

  task automatic model_reset();
    pc_m = 0; stk_m.delete(); flt_m = 0; code_m = 0;
  endtask

  task automatic model_step(input int e, input int o, input int t);
    if (e == 0 || flt_m != 0) return;
    case (o)
      0: pc_m = (pc_m + 1) % 65536;
      1: pc_m = t;
      2: pc_m = (pc_m + t) % 65536;
      3: if (stk_m.size() == DEPTH) begin flt_m = 1; code_m = 1; end
         else begin stk_m.push_back((pc_m + 1) % 65536); pc_m = t; end
      4: if (stk_m.size() == 0) begin flt_m = 1; code_m = 2; end
         else pc_m = stk_m.pop_back();
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int epc, input int edep,
                         input int eflt, input int ecode);
    chk({tag, " pc"},    int'(bus.pc),         epc);
    chk({tag, " depth"}, int'(bus.depth_o),    edep);
    chk({tag, " fault"}, int'(bus.fault),      eflt);
    chk({tag, " code"},  int'(bus.fault_code), ecode);
  endtask

  // Drive one command, let one rising edge pass, sample 1 time unit later.
  task automatic apply(input int e, input int o, input int t);
    bus.en     = e[0];
    bus.op     = o[2:0];
    bus.target = t[15:0];
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between edges; outputs are checked before any edge.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    chk_all(tag, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    int en; int op; int target;
    int pc; int depth;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset      = 1'b1;
    bus.en     = 1'b0;
    bus.op     = 3'd5;
    bus.target = '0;
    #7;
    chk_all("reset", 0, 0, 0, 0);
    #5;
    reset = 1'b0;

    vecs = '{
      '{1, 0, 0, 16'h0001, 0}, '{1, 0, 0, 16'h0002, 0}, '{1, 0, 0, 16'h0003, 0},
      '{1, 1, 16'hFFFE, 16'hFFFE, 0},
      '{1, 0, 0, 16'hFFFF, 0}, '{1, 0, 0, 16'h0000, 0},
      '{1, 1, 16'h0100, 16'h0100, 0},
      '{1, 2, 16'hFFFC, 16'h00FC, 0},
      '{1, 2, 16'h0010, 16'h010C, 0},
      '{1, 1, 16'h0010, 16'h0010, 0},
      '{1, 3, 16'h0200, 16'h0200, 1},
      '{1, 3, 16'h0300, 16'h0300, 2},
      '{1, 4, 0, 16'h0201, 1},
      '{1, 4, 0, 16'h0011, 0},
      '{0, 0, 0, 16'h0011, 0}, '{0, 0, 0, 16'h0011, 0}, '{0, 3, 16'h1234, 16'h0011, 0},
      '{1, 5, 16'h7777, 16'h0011, 0},
      '{1, 6, 16'h7777, 16'h0011, 0},
      '{1, 7, 16'h7777, 16'h0011, 0},
      '{1, 0, 0, 16'h0012, 0}
    };
    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].op, vecs[i].target);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].depth, 0, 0);
    end

    // Overflow: fill the stack, the ninth CALL faults and everything freezes.
    pulse_reset("ovf reset");
    for (int i = 0; i < DEPTH; i++) apply(1, 3, 16'h0100 + i);
    chk_all("ovf full", 16'h0107, DEPTH, 0, 0);
    apply(1, 3, 16'h0AAA);
    chk_all("ovf fault", 16'h0107, DEPTH, 1, 1);
    apply(1, 0, 0);
    chk_all("ovf inc frozen", 16'h0107, DEPTH, 1, 1);
    apply(1, 4, 0);
    chk_all("ovf ret frozen", 16'h0107, DEPTH, 1, 1);

    // Underflow: RET on empty stack; a later CALL must not change the code.
    pulse_reset("unf reset");
    apply(1, 4, 0);
    chk_all("unf fault", 0, 0, 1, 2);
    apply(1, 3, 16'h0400);
    chk_all("unf keep code", 0, 0, 1, 2);

    // Async reset mid-cycle with a non-empty stack.
    pulse_reset("ar reset0");
    apply(1, 3, 16'h0020); apply(1, 3, 16'h0030); apply(1, 3, 16'h0040);
    chk_all("ar depth3", 16'h0040, 3, 0, 0);
    #3;
    pulse_reset("ar async");

    // Randomized run against the model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      int e, o, t;
      if ((flt_m != 0 && $urandom_range(3) == 0) || $urandom_range(300) == 0) begin
        pulse_reset($sformatf("rnd%0d reset", n));
      end else begin
        e = ($urandom_range(9) != 0) ? 1 : 0;
        o = $urandom_range(7);
        t = $urandom_range(65535);
        apply(e, o, t);
        model_step(e, o, t);
        chk_all($sformatf("rnd%0d", n), pc_m, stk_m.size(), flt_m, code_m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
